sme_loader: RTL

- Front-end capture stage of the String Machine Engine; sits directly upstream of the comparator.
- Receives string and pattern characters serially on chardata, qualified by isstring/ispattern.
- Packs them into the flat buses the comparator consumes: str_reg_w, pat_reg_w, str_len, pat_len.
- Sequences the comparator through c_state: holds COMP until the comparator's ready pulse, or until a watchdog timeout.

---
 rtl/sme_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sme_loader.sv
// sme_loader: front-end capture stage of the String Machine Engine.
// Serially captures string and pattern characters and packs them into the
// flat buses consumed by the comparator, then holds the comparator in COMP
// until it signals ready or a watchdog expires.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   chardata   - ASCII character, sampled when isstring or ispattern is high
//   isstring   - chardata is a string character (wins over ispattern)
//   ispattern  - chardata is a pattern character
//   comp_ready - comparator result-valid pulse
//   str_reg_w  - packed string, byte 33 and the byte after the last char are 0x20
//   pat_reg_w  - packed pattern, first char in byte PAT_MAX-1
//   str_len    - stored string length (saturating)
//   pat_len    - stored pattern length (saturating)
//   c_state    - FSM state: 0 IDLE, 1 STR, 2 PAT, 3 COMP
//   ovf        - sticky, a char was dropped since the last string/pattern start
//   timeout    - one-cycle pulse when COMP is abandoned by the watchdog
module sme_loader #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 10,
    parameter int TIMEOUT = 127
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                chardata,
    input  logic                      isstring,
    input  logic                      ispattern,
    input  logic                      comp_ready,
    output logic [8*(STR_MAX+2)-1:0]  str_reg_w,
    output logic [8*PAT_MAX-1:0]      pat_reg_w,
    output logic [5:0]                str_len,
    output logic [3:0]                pat_len,
    output logic [2:0]                c_state,
    output logic                      ovf,
    output logic                      timeout
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] STR  = 3'd1;
    localparam logic [2:0] PAT  = 3'd2;
    localparam logic [2:0] COMP = 3'd3;

    localparam logic [7:0] SPACE = 8'h20;
    // Empty string: leading sentinel plus the trailing sentinel in byte STR_MAX.
    localparam logic [8*(STR_MAX+2)-1:0] STR_RST = {SPACE, SPACE, {(8*STR_MAX){1'b0}}};

    logic [2:0] next_state;
    logic [6:0] wd_cnt;
    logic       wd_last;

    logic str_start, str_append, pat_start, pat_append, comp_enter, wd_expire;

    logic [8*(STR_MAX+2)-1:0] str_nxt;
    logic [8*PAT_MAX-1:0]     pat_nxt;
    logic [5:0]               str_len_nxt;
    logic [3:0]               pat_len_nxt;
    logic                     ovf_nxt;
    logic [6:0]               wd_nxt;
    int                       str_k;
    int                       pat_k;

    assign wd_last = (wd_cnt == 7'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_state <= IDLE;
        end else begin
            c_state <= next_state;
        end
    end

    // Next-state logic; isstring has priority over ispattern everywhere.
    always_comb begin
        next_state = c_state;
        case (c_state)
            IDLE: begin
                if (isstring)       next_state = STR;
                else if (ispattern) next_state = PAT;
            end
            STR: begin
                if (isstring)       next_state = STR;
                else if (ispattern) next_state = PAT;
                else                next_state = IDLE;
            end
            PAT: begin
                if (!(ispattern && !isstring)) next_state = COMP;
            end
            COMP: begin
                if (comp_ready || wd_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: datapath strobes derived from state and inputs.
    always_comb begin
        str_start  = (c_state == IDLE) && isstring;
        str_append = (c_state == STR) && isstring;
        pat_start  = ((c_state == IDLE) || (c_state == STR)) && !isstring && ispattern;
        pat_append = (c_state == PAT) && ispattern && !isstring;
        comp_enter = (c_state == PAT) && !(ispattern && !isstring);
        // comp_ready wins over an expiring watchdog.
        wd_expire  = (c_state == COMP) && !comp_ready && wd_last;
    end

    // Datapath next values; nothing here changes while in COMP except the watchdog.
    always_comb begin
        str_nxt     = str_reg_w;
        pat_nxt     = pat_reg_w;
        str_len_nxt = str_len;
        pat_len_nxt = pat_len;
        ovf_nxt     = ovf;
        wd_nxt      = wd_cnt;
        str_k       = int'(str_len);
        pat_k       = int'(pat_len);

        if (str_start) begin
            str_nxt                        = STR_RST;
            str_nxt[8*STR_MAX +: 8]        = chardata;
            str_nxt[8*(STR_MAX-1) +: 8]    = SPACE;
            str_len_nxt                    = 6'd1;
            ovf_nxt                        = 1'b0;
        end else if (str_append) begin
            if (str_k < STR_MAX) begin
                str_nxt[8*(STR_MAX-str_k) +: 8] = chardata;
                // Trailing sentinel moves one byte down behind the new char.
                if (str_k < STR_MAX - 1 || str_k == STR_MAX - 1)
                    str_nxt[8*(STR_MAX-1-str_k) +: 8] = SPACE;
                str_len_nxt = str_len + 6'd1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end

        if (pat_start) begin
            pat_nxt                      = '0;
            pat_nxt[8*(PAT_MAX-1) +: 8]  = chardata;
            pat_len_nxt                  = 4'd1;
            ovf_nxt                      = 1'b0;
        end else if (pat_append) begin
            if (pat_k < PAT_MAX) begin
                pat_nxt[8*(PAT_MAX-1-pat_k) +: 8] = chardata;
                pat_len_nxt = pat_len + 4'd1;
            end else begin
                ovf_nxt = 1'b1;
            end
        end

        if (comp_enter)
            wd_nxt = 7'd0;
        else if (c_state == COMP)
            wd_nxt = wd_cnt + 7'd1;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_reg_w <= STR_RST;
            pat_reg_w <= '0;
            str_len   <= 6'd0;
            pat_len   <= 4'd0;
            ovf       <= 1'b0;
            timeout   <= 1'b0;
            wd_cnt    <= 7'd0;
        end else begin
            str_reg_w <= str_nxt;
            pat_reg_w <= pat_nxt;
            str_len   <= str_len_nxt;
            pat_len   <= pat_len_nxt;
            ovf       <= ovf_nxt;
            timeout   <= wd_expire;
            wd_cnt    <= wd_nxt;
        end
    end

endmodule
